// File: rtl/matrix_mult_stream.sv
// Streaming NxN matrix multiply-accumulate engine: one operand pair per
// transaction, one result row per cycle through pipelined multipliers.
module matrix_mult_stream #(
    parameter int N          = 4,
    parameter int WIDTH      = 16,
    parameter int MUL_STAGES = 10,
    parameter int SIGNED     = 0,
    parameter int OUT_W      = 2 * WIDTH + $clog2(N)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     acc,
    input  logic [N*N*WIDTH-1:0]     a_flat,
    input  logic [N*N*WIDTH-1:0]     b_flat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N*N*OUT_W-1:0]     c_flat,
    output logic                     busy
);

    localparam int NN    = N * N;
    localparam int PW    = 2 * WIDTH;
    localparam int ROW_W = $clog2(N);
    localparam logic SGN = (SIGNED != 0);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic                   acc_q, acc_d;
    logic [NN*WIDTH-1:0]    a_q, a_d, b_q, b_d;
    logic [NN*OUT_W-1:0]    c_q, c_d;
    logic                   out_valid_q, out_valid_d;
    logic                   in_ready_q, in_ready_d;
    logic                   busy_q, busy_d;

    logic [MUL_STAGES-1:0]  vld_q, vld_d;
    logic [ROW_W-1:0]       prow_q [MUL_STAGES];
    logic [ROW_W-1:0]       prow_d [MUL_STAGES];
    logic [PW-1:0]          prod_q [MUL_STAGES][NN];
    logic [PW-1:0]          prod_d [MUL_STAGES][NN];
    logic [OUT_W-1:0]       sum_q [N];
    logic [OUT_W-1:0]       sum_d [N];
    logic                   sum_vld_q, sum_vld_d;
    logic [ROW_W-1:0]       sum_row_q, sum_row_d;

    // Low 2*WIDTH bits of the extended product are correct for both signednesses
    function automatic logic [PW-1:0] mul(input logic [WIDTH-1:0] x,
                                          input logic [WIDTH-1:0] y);
        logic [PW-1:0] xe;
        logic [PW-1:0] ye;
        xe = {{WIDTH{SGN & x[WIDTH-1]}}, x};
        ye = {{WIDTH{SGN & y[WIDTH-1]}}, y};
        return xe * ye;
    endfunction

    function automatic logic [OUT_W-1:0] ext(input logic [PW-1:0] p);
        return {{(OUT_W-PW){SGN & p[PW-1]}}, p};
    endfunction

    always_comb begin
        vld_d[0]  = (state_q == ISSUE);
        prow_d[0] = row_q;
        for (int kj = 0; kj < NN; kj++) begin
            prod_d[0][kj] = mul(
                a_q[(int'(row_q) * N + kj / N) * WIDTH +: WIDTH],
                b_q[kj * WIDTH +: WIDTH]);
        end
        for (int s = 1; s < MUL_STAGES; s++) begin
            vld_d[s]  = vld_q[s-1];
            prow_d[s] = prow_q[s-1];
            for (int kj = 0; kj < NN; kj++) begin
                prod_d[s][kj] = prod_q[s-1][kj];
            end
        end
    end

    // prod index kj = k*N + j, so column j sums over k with stride N
    always_comb begin
        sum_vld_d = vld_q[MUL_STAGES-1];
        sum_row_d = prow_q[MUL_STAGES-1];
        for (int j = 0; j < N; j++) begin
            sum_d[j] = '0;
            for (int k = 0; k < N; k++) begin
                sum_d[j] = sum_d[j] + ext(prod_q[MUL_STAGES-1][k * N + j]);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        acc_d       = acc_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        out_valid_d = out_valid_q;
        if (sum_vld_q) begin
            for (int j = 0; j < N; j++) begin
                c_d[(int'(sum_row_q) * N + j) * OUT_W +: OUT_W] =
                    (acc_q ? c_q[(int'(sum_row_q) * N + j) * OUT_W +: OUT_W]
                           : '0) + sum_q[j];
            end
        end
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a_flat;
                    b_d     = b_flat;
                    acc_d   = acc;
                    row_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (row_q == ROW_W'(N - 1)) begin
                    state_d = DRAIN;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            DRAIN: begin
                if (sum_vld_q && sum_row_q == ROW_W'(N - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            acc_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            vld_q       <= '0;
            sum_vld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            acc_q       <= acc_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            vld_q       <= vld_d;
            sum_vld_q   <= sum_vld_d;
        end
    end

    // Datapath payload is qualified by the valid bits, so it needs no reset
    always_ff @(posedge clk) begin
        prow_q    <= prow_d;
        prod_q    <= prod_d;
        sum_q     <= sum_d;
        sum_row_q <= sum_row_d;
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign c_flat    = c_q;

endmodule
